// File: rtl/ay_access_sched.sv
// ay_access_sched -- register-access scheduler for the AY-3-8910 PSG core.
//
// Arbitrates CPU-bridge accesses against a player write stream (buffered in a
// small FIFO) and turns each access into the PSG two-step bus sequence:
// address-latch write, gap, data write/read, gap. Accesses are atomic.
//
// Optional feature macro: AY_SCHED_SHADOW_EN
//   When defined, a 16x8 shadow of written PSG registers serves CPU reads of
//   R0..R13 in two cycles without touching the PSG.
//
// Ports:
//   clk, reset                 PSG clock, async active-high reset
//   cpu_req/we/reg/wdata       CPU level request (hold until cpu_ack)
//   cpu_ack, cpu_rdata         completion pulse, read result (held)
//   ply_valid/reg/data         player write offer
//   ply_ready, ply_level       FIFO not full, FIFO occupancy
//   ay_a0, ay_wr_tick,
//   ay_rd_tick, ay_wdata       PSG bus side
//   ay_rdata                   PSG read data
module ay_access_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [3:0]                    cpu_reg,
    input  logic [7:0]                    cpu_wdata,
    output logic                          cpu_ack,
    output logic [7:0]                    cpu_rdata,
    input  logic                          ply_valid,
    input  logic [3:0]                    ply_reg,
    input  logic [7:0]                    ply_data,
    output logic                          ply_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ply_level,
    output logic                          ay_a0,
    output logic                          ay_wr_tick,
    output logic                          ay_rd_tick,
    output logic [7:0]                    ay_wdata,
    input  logic [7:0]                    ay_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GA_LOAD = GW'(GAP - 1);
    localparam logic [GW-1:0] GD_LOAD = (GAP > 1) ? GW'(GAP - 2) : '0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_GAPA = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAPD = 3'd4;
    localparam logic [2:0] S_SHRD = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d, cpu_q, cpu_d;
    logic [3:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    starve_q, starve_d;
    logic          a0_q, a0_d, ack_q, ack_d, live_q, live_d;
    logic [7:0]    wdata_q, wdata_d, rdata_q, rdata_d;

    // Player FIFO: {reg, data} entries
    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic          full, fifo_ne, push, pop;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign fifo_ne = (level_q != '0);
    assign push    = ply_valid && !full;

    // Arbitration: CPU has priority unless it has starved a waiting FIFO
    logic idle, grant_fifo, grant_cpu, shadow_hit;
    logic [7:0] shadow_val;
    assign idle       = (state_q == S_IDLE);
    assign grant_fifo = idle && fifo_ne && (!cpu_req || starve_q == 3'd4);
    assign grant_cpu  = idle && cpu_req && !grant_fifo;
    assign pop        = grant_fifo;

`ifdef AY_SCHED_SHADOW_EN
    logic [7:0] shadow_q [16];

    function automatic logic [7:0] shadow_mask(input logic [3:0] r, input logic [7:0] v);
        case (r)
            4'd1, 4'd3, 4'd5, 4'd13:  shadow_mask = {4'h0, v[3:0]};
            4'd6, 4'd8, 4'd9, 4'd10:  shadow_mask = {3'h0, v[4:0]};
            default:                  shadow_mask = v;
        endcase
    endfunction

    assign shadow_hit = grant_cpu && !cpu_we && (cpu_reg < 4'd14);
    assign shadow_val = shadow_mask(cpu_reg, shadow_q[cpu_reg]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
        end else if (state_q == S_DATA && we_q) begin
            shadow_q[reg_q] <= data_q;
        end
    end
`else
    assign shadow_hit = 1'b0;
    assign shadow_val = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        cpu_d    = cpu_q;
        reg_d    = reg_q;
        data_d   = data_q;
        starve_d = starve_q;
        a0_d     = a0_q;
        wdata_d  = wdata_q;
        ack_d    = shadow_hit;
        live_d   = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_fifo) begin
                    we_d     = 1'b1;
                    cpu_d    = 1'b0;
                    reg_d    = mem_q[rptr_q][11:8];
                    data_d   = mem_q[rptr_q][7:0];
                    starve_d = '0;
                end else if (grant_cpu) begin
                    we_d     = cpu_we;
                    cpu_d    = 1'b1;
                    reg_d    = cpu_reg;
                    data_d   = cpu_wdata;
                    starve_d = fifo_ne ? starve_q + 3'd1 : 3'd0;
                end
                if (shadow_hit) begin
                    state_d = S_SHRD;
                    rdata_d = shadow_val;
                end else if (grant_fifo || grant_cpu) begin
                    state_d = S_ADDR;
                    a0_d    = 1'b0;
                    wdata_d = {4'h0, grant_fifo ? mem_q[rptr_q][11:8] : cpu_reg};
                end
            end
            S_ADDR: begin
                state_d = S_GAPA;
                cnt_d   = GA_LOAD;
            end
            S_GAPA: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    a0_d    = 1'b1;
                    if (we_q) wdata_d = data_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                // The IDLE cycle itself is the last cycle of the data gap,
                // which gives the 2+2*GAP access period.
                ack_d   = cpu_q;
                live_d  = cpu_q && !we_q;
                cnt_d   = GD_LOAD;
                state_d = (GAP > 1) ? S_GAPD : S_IDLE;
            end
            S_GAPD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_SHRD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // PSG read data is taken live on the ack cycle, then held
        if (live_q) rdata_d = ay_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            cpu_q    <= 1'b0;
            reg_q    <= '0;
            data_q   <= '0;
            starve_q <= '0;
            a0_q     <= 1'b0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            live_q   <= 1'b0;
            rdata_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            cpu_q    <= cpu_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            starve_q <= starve_d;
            a0_q     <= a0_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            live_q   <= live_d;
            rdata_q  <= rdata_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q  <= level_q + LW'(push) - LW'(pop);
        end
    end

    // Storage needs no reset: occupancy alone defines valid entries
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {ply_reg, ply_data};
    end

    assign cpu_ack    = ack_q;
    assign cpu_rdata  = live_q ? ay_rdata : rdata_q;
    assign ply_ready  = !full;
    assign ply_level  = level_q;
    assign ay_a0      = a0_q;
    assign ay_wdata   = wdata_q;
    assign ay_wr_tick = (state_q == S_ADDR) || (state_q == S_DATA && we_q);
    assign ay_rd_tick = (state_q == S_DATA) && !we_q;

endmodule

// File: doc/ay_access_sched.md
# ay_access_sched

Register-access scheduler for the AY-3-8910 PSG core, in the PSG clock domain. It takes register reads and writes from the CPU bridge and from a hardware player stream buffered in a small FIFO. It arbitrates between the two sources and turns each access into the PSG's two-step bus protocol: an address-latch write, then a data write or read. Accesses are atomic: the two sources never interleave inside one access.

## Interface
- `FIFO_DEPTH`, default 8: player FIFO entries; power of two, 2..32.
- `GAP`, default 2: idle cycles after each PSG tick; must be ≥1.
- `clk` in 1: PSG clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: level request; hold high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_reg` in 4: PSG register index.
- `cpu_wdata` in 8: write data.
- `cpu_ack` out 1: one-cycle pulse when the access completes.
- `cpu_rdata` out 8: read result; valid when `cpu_ack`=1, held until the next read ack.
- `ply_valid` in 1: player write offered.
- `ply_reg` in 4: player register index.
- `ply_data` in 8: player write data.
- `ply_ready` out 1: FIFO not full; a push occurs when `ply_valid && ply_ready`.
- `ply_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `ay_a0` out 1: PSG address/data select; 0 = address latch.
- `ay_wr_tick` out 1: one-cycle PSG write strobe.
- `ay_rd_tick` out 1: one-cycle PSG read strobe.
- `ay_wdata` out 8: PSG write data.
- `ay_rdata` in 8: PSG read data.

## Operation
- **States:**
  - IDLE
  - ADDR: `ay_a0`=0, `ay_wdata`={4'b0,reg}, `ay_wr_tick`=1 for one cycle.
  - GAP_A: GAP cycles.
  - DATA: `ay_a0`=1; a write drives `ay_wdata`=data with `ay_wr_tick`=1; a read drives `ay_rd_tick`=1 only.
  - GAP_D: GAP cycles, then IDLE.
- **Acceptance in IDLE:**
  - `cpu_req`=1 wins over a non-empty FIFO.
  - Starvation guard: after 4 consecutive CPU accesses granted while the FIFO was non-empty, the next grant goes to the FIFO if it is non-empty.
  - The starvation counter clears on every FIFO grant, and whenever the FIFO is empty at a grant.
  - Op, reg and data are latched at acceptance. Later input changes are ignored until the access completes.
  - A FIFO entry pops on the acceptance cycle.
- **Read capture:** `ay_rdata` is sampled on the first GAP_D cycle into `cpu_rdata`.
- **CPU ack:**
  - `cpu_ack` pulses on that same first GAP_D cycle, for both reads and writes.
  - CPU acks only; player accesses produce no ack.
  - `cpu_req` must drop the cycle after the ack. If it is still high, that counts as a new request.
- **FIFO:**
  - `ply_ready` = !full.
  - A push and a pop in the same cycle leave `ply_level` unchanged.
  - When full, no push occurs even if a pop happens that cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - The FIFO empties; `ply_level`=0 and `ply_ready`=1.
  - The starvation counter and `cpu_rdata` clear.
  - An access in flight is abandoned; no ack is issued.

## Timing
- Acceptance cycle T. ADDR tick at T+1. DATA tick at T+2+GAP. `cpu_ack` and read capture at T+3+GAP.
- The block is back in IDLE at T+2+2·GAP. Back-to-back accesses therefore run every 2+2·GAP cycles.
- Ticks are single-cycle and never overlap. `ay_a0` and `ay_wdata` hold their values through the following gap.
- A FIFO push is visible to the arbiter the cycle after the push; the minimum latency from push to pop is 1 cycle.

## Configuration
- **`AY_SCHED_SHADOW_EN` defined:** adds a 16×8 shadow register file.
  - Shadow updates: every completed DATA write, from either source, updates `shadow[reg]`. Reset clears the shadow to 0.
  - CPU reads of regs 0–13:
    - served from the shadow; the PSG is not touched;
    - `cpu_ack` and `cpu_rdata` come at T+1;
    - IDLE again at T+2.
  - Shadow read masking: R1, R3, R5, R13 return bits [3:0]; R6, R8, R9, R10 return bits [4:0]; all other bits read 0.
  - Regs 14–15 (I/O ports) still use the full PSG read sequence.
- **Undefined:** no shadow; every read uses the PSG sequence.

## Test plan
- GAP=2, CPU write reg 7 ← 0x38 accepted at T:
  - ADDR tick at T+1 with `ay_wdata`=0x07, `ay_a0`=0;
  - DATA tick at T+4 with 0x38, `ay_a0`=1;
  - `cpu_ack` at T+5.
- CPU read of reg 14 with `ay_rdata`=0xA5 → `ay_rd_tick` at T+4, `cpu_ack` at T+5 with `cpu_rdata`=0xA5; no `ay_wr_tick` in the DATA phase.
- Push 9 entries into FIFO_DEPTH=8 with no pops → `ply_ready`=0 after the 8th push and the 9th is held off; entries drain in order, each a two-tick pair, until `ply_level`=0.
- CPU requests back-to-back with the FIFO non-empty → 4 CPU accesses, then 1 FIFO access, repeating; no ADDR/DATA interleave between sources.
- Assert reset during GAP_A of a CPU write:
  - all outputs are 0 immediately;
  - no DATA tick and no ack;
  - `ply_level`=0 after release.
- With `AY_SCHED_SHADOW_EN`: write R1 ← 0xFF, then read R1 → `cpu_rdata`=0x0F at T+1 with no PSG ticks during the read.
